// File: rtl/if_stage_sequencer.sv
// if_stage_sequencer: instruction-fetch sequencer.
// Owns the PC, issues instruction-memory fetches, and drives the IF/ID register.
// The PC follows jump and branch redirects from the ID-stage controller.
// A one-entry skid buffer holds a word that returns while the pipe is stalled.
// Optional build macro IF_PERF_CNT_EN adds fetch and flush event counters.
module if_stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_jump,
  input  logic [31:0] j_next_pc,
  input  logic        is_branch,
  input  logic [31:0] branch_target,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic        load_valid;
  logic        flush_evt;

  // A stall masks redirects: the comparator operands in ID are not final yet.
  assign redirect    = !stall && (is_jump || is_branch);
  assign redirect_pc = is_jump ? j_next_pc : branch_target;
  assign pc_plus4    = pc_q + 32'd4;

  assign imem_req   = (state_q == S_FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_inst  = ifid_inst_q;
  assign ifid_pc4   = ifid_pc4_q;

  // State, PC, IF/ID and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= NOP_INST;
      ifid_pc4_q   <= 32'd0;
      skid_inst_q  <= NOP_INST;
      skid_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Next-state: stall > redirect > flush > ready > wait-state bubble
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_inst_d  = skid_inst_q;
    skid_pc4_d   = skid_pc4_q;
    load_valid   = 1'b0;
    flush_evt    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (stall) begin
          // Park a returning word so the request can drop until release
          if (imem_ready) begin
            skid_inst_d = imem_rdata;
            skid_pc4_d  = pc_plus4;
            state_d     = S_HOLD;
          end
        end else if (redirect) begin
          pc_d         = redirect_pc;
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP_INST;
          ifid_pc4_d   = 32'd0;
          flush_evt    = 1'b1;
        end else if (flush) begin
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP_INST;
          ifid_pc4_d   = 32'd0;
          flush_evt    = 1'b1;
        end else if (imem_ready) begin
          pc_d         = pc_plus4;
          ifid_valid_d = 1'b1;
          ifid_inst_d  = imem_rdata;
          ifid_pc4_d   = pc_plus4;
          load_valid   = 1'b1;
        end else begin
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP_INST;
          ifid_pc4_d   = 32'd0;
        end
      end
      S_HOLD: begin
        if (stall) begin
          state_d = S_HOLD;
        end else if (redirect) begin
          pc_d         = redirect_pc;
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP_INST;
          ifid_pc4_d   = 32'd0;
          flush_evt    = 1'b1;
          state_d      = S_FETCH;
        end else if (flush) begin
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP_INST;
          ifid_pc4_d   = 32'd0;
          flush_evt    = 1'b1;
          state_d      = S_FETCH;
        end else begin
          pc_d         = pc_plus4;
          ifid_valid_d = 1'b1;
          ifid_inst_d  = skid_inst_q;
          ifid_pc4_d   = skid_pc4_q;
          load_valid   = 1'b1;
          state_d      = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  // Event counters; wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (load_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush_evt)  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = load_valid ^ flush_evt;
`endif

endmodule

// File: tb/tb_if_stage_sequencer.sv
// Directed bench for if_stage_sequencer; expected values are hand-computed.
module tb_if_stage_sequencer;
  logic        clk = 1'b0;
  logic        rst, stall, is_jump, is_branch, flush, imem_ready;
  logic [31:0] j_next_pc, branch_target, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, pc, ifid_inst, ifid_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  if_stage_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall),
    .is_jump(is_jump), .j_next_pc(j_next_pc),
    .is_branch(is_branch), .branch_target(branch_target),
    .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, take the edge, settle 1 time unit
  task automatic cyc(input logic st, input logic j, input logic [31:0] jt,
                     input logic br, input logic [31:0] bt, input logic fl,
                     input logic rdy, input logic [31:0] rd);
    stall = st; is_jump = j; j_next_pc = jt; is_branch = br; branch_target = bt;
    flush = fl; imem_ready = rdy; imem_rdata = rd;
    @(posedge clk); #1;
  endtask

  task automatic ifid(input string tag, input logic v, input logic [31:0] inst,
                      input logic [31:0] p4, input logic [31:0] p);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    chk({tag, ".inst"}, ifid_inst, inst);
    chk({tag, ".pc4"}, ifid_pc4, p4);
    chk({tag, ".pc"}, pc, p);
  endtask

  initial begin
    rst = 1'b1;
    stall = 0; is_jump = 0; j_next_pc = 0; is_branch = 0; branch_target = 0;
    flush = 0; imem_ready = 0; imem_rdata = 0;
    #1;
    chk("req_in_rst", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    ifid("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0; #1;
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);
    chk("addr_after_rst", imem_addr, 32'h0);

    // Zero-wait fetches
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h8C01_0004);
    ifid("fetch0", 1'b1, 32'h8C01_0004, 32'h4, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
    ifid("fetch1", 1'b1, 32'h1111_1111, 32'h8, 32'h8);

    // Jump at pc=8, word fetched this cycle is discarded
    cyc(0, 1, 32'h40, 0, 0, 0, 1, 32'hDEAD_BEEF);
    ifid("jump", 1'b0, 32'h0, 32'h0, 32'h40);
    chk("jump.addr", imem_addr, 32'h40);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    ifid("jump_tgt", 1'b1, 32'h2222_2222, 32'h44, 32'h44);

    // Stall with ready at pc=0x10 -> HOLD, release loads skid
    cyc(0, 1, 32'h10, 0, 0, 0, 1, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h0043_0820);
    ifid("hold", 1'b0, 32'h0, 32'h0, 32'h10);
    chk("hold.req", {31'd0, imem_req}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hBAD0_0001);
    ifid("hold2", 1'b0, 32'h0, 32'h0, 32'h10);
    chk("hold2.req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hBAD0_0002);
    ifid("release", 1'b1, 32'h0043_0820, 32'h14, 32'h14);
    chk("release.req", {31'd0, imem_req}, 32'd1);

    // Stall masks branch; released branch discards skid
    cyc(1, 0, 0, 1, 32'h100, 0, 1, 32'h3333_3333);
    ifid("st_br", 1'b1, 32'h0043_0820, 32'h14, 32'h14);
    cyc(0, 0, 0, 1, 32'h100, 0, 0, 32'h0);
    ifid("br_rel", 1'b0, 32'h0, 32'h0, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h4444_4444);
    ifid("br_tgt", 1'b1, 32'h4444_4444, 32'h104, 32'h104);

    // Stall without ready stays in FETCH
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("st_nordy.req", {31'd0, imem_req}, 32'd1);
    chk("st_nordy.pc", pc, 32'h104);

    // Jump wins over branch
    cyc(0, 1, 32'h20, 1, 32'h200, 0, 1, 32'h0);
    chk("jmp_wins.pc", pc, 32'h20);

    // Three wait states then ready
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 32'hBAD0_0003);
      chk($sformatf("wait%0d.valid", i), {31'd0, ifid_valid}, 32'd0);
      chk($sformatf("wait%0d.inst", i), ifid_inst, 32'h0);
      chk($sformatf("wait%0d.pc", i), pc, 32'h20);
    end
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555);
    ifid("wait_rdy", 1'b1, 32'h5555_5555, 32'h24, 32'h24);

    // Flush alone: refetch same pc
    cyc(0, 0, 0, 0, 0, 1, 1, 32'hBAD0_0004);
    ifid("flush", 1'b0, 32'h0, 32'h0, 32'h24);

    // Flush in HOLD discards skid, pc unchanged
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h6666_6666);
    chk("hold3.req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h0);
    ifid("hold_flush", 1'b0, 32'h0, 32'h0, 32'h24);
    chk("hold_flush.req", {31'd0, imem_req}, 32'd1);

    // PC wrap
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    ifid("wrap", 1'b1, 32'h7777_7777, 32'h0, 32'h0);

    // Reset while in HOLD
    cyc(0, 1, 32'h30, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h9999_9999);
    chk("pre_rst.req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    ifid("rst_hold", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0; #1;
    chk("rst_hold.req", {31'd0, imem_req}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h8888_8888);
    ifid("post_rst", 1'b1, 32'h8888_8888, 32'h4, 32'h4);

    // Four more fetches (5 total since reset) and two jumps
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 32'h1000 + i);
    chk("seq.pc", pc, 32'h14);
    cyc(0, 1, 32'h80, 0, 0, 0, 1, 32'h0);
    cyc(0, 1, 32'h90, 0, 0, 0, 1, 32'h0);
    chk("seq2.pc", pc, 32'h90);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd5);
    chk("perf_flush", perf_flush_cnt, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
